motion_window_streamer: RTL and testbench
=========================================

// Module: motion_window_streamer
// PURPOSE
//  Upstream feeder of the gesture similarity stage. Captures one signed motion vector per frame
//  into a WIN-deep circular history, then, per new frame, streams the window oldest-first against
//  every library gesture (NUM_GEST*WIN beats), fetching library vectors from a 1-cycle-latency ROM.
//  The consumer sees vector/library pairs aligned on the same beat, with gesture and slot tags.
// PARAMETERS
//  VW        6   motion/library component width, two's complement
//  WIN       16  vectors per window (power of 2)
//  NUM_GEST  26  library gestures; stream length NUM_GEST*WIN = 416 beats
//  AW        9   library address width, $clog2(NUM_GEST*WIN)
// PORTS
//  i_clk       in   1      clock, single domain
//  i_rst_n     in   1      asynchronous, active-low reset
//  i_mv_valid  in   1      one-cycle pulse: new frame vector on i_mv_x/y
//  i_mv_x      in   VW     signed motion x
//  i_mv_y      in   VW     signed motion y
//  i_clear     in   1      synchronous flush of history and stream
//  i_dst_ready in   1      consumer idle; a stream may launch only while high
//  o_lib_en    out  1      ROM read enable
//  o_lib_addr  out  AW     ROM address = gest*WIN + slot
//  i_lib_x     in   VW     ROM data x, valid cycle after o_lib_en
//  i_lib_y     in   VW     ROM data y
//  o_valid     out  1      beat valid
//  o_first     out  1      first beat of stream (gest 0, slot 0)
//  o_last      out  1      final beat (gest NUM_GEST-1, slot WIN-1)
//  o_gest      out  5      gesture index of beat
//  o_slot      out  4      window slot of beat, 0 = oldest
//  o_vec_x/y   out  VW     history vector for slot
//  o_lib_x/y   out  VW     library vector for (gest, slot)
//  o_full      out  1      history holds WIN vectors
//  o_overrun   out  1      one-cycle pulse: pending vector overwritten
// BEHAVIOUR
//  - Reset: every output 0; state FILL; fill count 0; pending empty; history contents don't-care.
//  - States: FILL -> IDLE -> ADDR -> DRAIN -> IDLE.
//    FILL: i_mv_valid writes history at wr_ptr, wr_ptr++, count++; count reaching WIN -> IDLE, and
//      that write arms a launch.
//    IDLE: each commit arms launch; armed & i_dst_ready -> ADDR (launch clears arm). Armed
//      launches never queue: at most one stream per arm.
//    ADDR: exactly NUM_GEST*WIN cycles of o_lib_en=1, addr 0..415 ascending; slot inner, gest outer.
//    DRAIN: 2 cycles flushing pipeline, then IDLE.
//  - Pipeline: addr issued cycle t; ROM data cycle t+1; all beat outputs registered, valid t+2.
//    History read (oldest = wr_ptr + slot, mod WIN) delayed to align with ROM data. Latency
//    launch->o_first = 2 cycles; beats contiguous, no bubbles; o_first/o_last single-cycle.
//  - Vector during ADDR/DRAIN: stored in single pending register; committed on entry to IDLE
//    (counts as commit, arms launch). Second vector while pending: overwrite, o_overrun pulse.
//    Window snapshot is therefore stable for the whole stream.
//  - i_mv_valid in IDLE with pending set: cannot occur (pending commits on IDLE entry).
//  - i_clear (priority over all): next cycle state FILL, count 0, wr_ptr 0, pending empty, arm 0,
//    in-flight beats squashed (o_valid/o_first/o_last 0 next cycle, no o_last emitted).
//    i_mv_valid same cycle as i_clear is dropped.
//  - Async reset mid-stream: outputs 0 immediately; same state as clear.
//  - Widths: vectors passed unmodified, no arithmetic; wr_ptr and slot wrap mod WIN naturally.
//  - o_full = (count == WIN); count saturates at WIN.
// STRUCTURE
//  - gesture_pkg: VW, WIN, NUM_GEST, AW constants; typedef struct packed {logic signed [VW-1:0]
//    x, y;} mv_t; typedef enum {FILL, IDLE, ADDR, DRAIN} mws_state_t.
//  - Sub-module mv_history_ram: WIN x mv_t circular store, write port + wr_ptr, registered
//    read by relative slot (oldest-first). Top holds FSM, counters, pending reg, pipeline regs.
// TESTING (ROM model: x = addr[5:0], y = ~addr[5:0], 1-cycle latency)
//  1 Reset, 15 vectors (x=k,y=-k) -> no o_lib_en, o_full=0; 16th with ready=1 -> o_first 2 cycles
//    after ADDR entry, 416 contiguous beats, beat0 vec=(0,0), beat15 vec=(15,-15), o_last at 416.
//  2 Alignment: every beat n -> o_lib_x == n[5:0], o_lib_y == ~n[5:0], o_gest=n/16, o_slot=n%16.
//  3 Vectors A then B during stream -> o_overrun once on B; after stream B committed, next stream
//    slot15 = B, slot0 = oldest survivor (wrap across index 15->0).
//  4 i_dst_ready low 100 cycles after arm -> no beats; raise -> exactly one stream.
//  5 i_clear at beat 200 -> o_valid 0 next cycle, no o_last; o_full=0; 16 new vectors to stream.
//  6 i_rst_n low mid-ADDR -> all outputs 0 asynchronously; after release behaves as test 1.

Source files
------------

// File: rtl/gesture_pkg.sv
// rtl/gesture_pkg.sv - shared constants, motion vector type and streamer state encoding
package gesture_pkg;

    localparam int VW       = 6;                    // vector component width, two's complement
    localparam int WIN      = 16;                   // vectors per window, power of 2
    localparam int NUM_GEST = 26;                   // library gestures
    localparam int AW       = 9;                    // library address width
    localparam int SW       = $clog2(WIN);          // slot index width
    localparam int GW       = 5;                    // gesture index width
    localparam int CW       = $clog2(WIN + 1);      // fill count width, holds WIN itself

    typedef struct packed {
        logic signed [VW-1:0] x;
        logic signed [VW-1:0] y;
    } mv_t;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        IDLE  = 2'd1,
        ADDR  = 2'd2,
        DRAIN = 2'd3
    } mws_state_t;

endpackage

// File: rtl/mv_history_ram.sv
// rtl/mv_history_ram.sv - WIN-deep circular motion vector store with oldest-first registered read
//
// Ports:
//   i_clk, i_rst_n   clock, asynchronous active-low reset (write pointer only)
//   i_clear          synchronous pointer reset
//   i_we, i_wdata    write one packed {x, y} vector at the write pointer, pointer advances
//   i_rd_slot        relative slot, 0 = oldest entry
//   o_rd_data        registered read data, valid the cycle after i_rd_slot
module mv_history_ram
    import gesture_pkg::*;
(
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_clear,
    input  logic            i_we,
    input  logic [2*VW-1:0] i_wdata,
    input  logic [SW-1:0]   i_rd_slot,
    output logic [2*VW-1:0] o_rd_data
);

    logic [2*VW-1:0] mem_q [WIN];
    logic [2*VW-1:0] rd_data_q;
    logic [SW-1:0]   wr_ptr_q;
    logic [SW-1:0]   rd_idx;

    // The write pointer points at the oldest entry once the store is full,
    // so slot 0 maps onto it; the sum wraps mod WIN by width.
    assign rd_idx = wr_ptr_q + i_rd_slot;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_q <= '0;
        end else if (i_clear) begin
            wr_ptr_q <= '0;
        end else if (i_we) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
        end
    end

    // Contents need no reset: every slot is written before the first stream.
    always_ff @(posedge i_clk) begin
        if (i_we && !i_clear) begin
            mem_q[wr_ptr_q] <= i_wdata;
        end
        rd_data_q <= mem_q[rd_idx];
    end

    assign o_rd_data = rd_data_q;

endmodule

// File: rtl/motion_window_streamer.sv
// rtl/motion_window_streamer.sv - streams the motion history window against every library gesture
//
// Ports:
//   i_clk, i_rst_n            clock, asynchronous active-low reset
//   i_mv_valid, i_mv_x/y      per-frame motion vector pulse
//   i_clear                   synchronous flush of history and stream
//   i_dst_ready               consumer idle, gates stream launch
//   o_lib_en, o_lib_addr      library ROM read (addr = gest*WIN + slot)
//   i_lib_x/y                 ROM data, one cycle after o_lib_en
//   o_valid, o_first, o_last  beat framing
//   o_gest, o_slot            beat tags, slot 0 = oldest vector
//   o_vec_x/y, o_lib_x/y      aligned history / library pair
//   o_full, o_overrun         history full, pending vector overwritten pulse
module motion_window_streamer
    import gesture_pkg::*;
(
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_mv_valid,
    input  logic [VW-1:0] i_mv_x,
    input  logic [VW-1:0] i_mv_y,
    input  logic          i_clear,
    input  logic          i_dst_ready,
    output logic          o_lib_en,
    output logic [AW-1:0] o_lib_addr,
    input  logic [VW-1:0] i_lib_x,
    input  logic [VW-1:0] i_lib_y,
    output logic          o_valid,
    output logic          o_first,
    output logic          o_last,
    output logic [GW-1:0] o_gest,
    output logic [SW-1:0] o_slot,
    output logic [VW-1:0] o_vec_x,
    output logic [VW-1:0] o_vec_y,
    output logic [VW-1:0] o_lib_x,
    output logic [VW-1:0] o_lib_y,
    output logic          o_full,
    output logic          o_overrun
);

    mws_state_t    state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic          arm_q, arm_d;
    logic          pend_v_q, pend_v_d;
    mv_t           pend_q, pend_d;
    logic [GW-1:0] gest_q, gest_d;
    logic [SW-1:0] slot_q, slot_d;
    logic          drain_q, drain_d;
    logic          overrun_q, overrun_d;

    // Stage 1: tags of the address issued last cycle, lined up with ROM data.
    logic          v1_q, first1_q, last1_q;
    logic [GW-1:0] gest1_q;
    logic [SW-1:0] slot1_q;

    // Stage 2: registered beat outputs.
    logic          valid_q, first_q, last_q;
    logic [GW-1:0] out_gest_q;
    logic [SW-1:0] out_slot_q;
    mv_t           vec_q, lib_q;

    logic          we;
    mv_t           wdata;
    mv_t           mv_in;
    logic [2*VW-1:0] hist_rd;
    logic          in_addr, addr_first, addr_last, slot_end;

    assign mv_in      = {i_mv_x, i_mv_y};
    assign in_addr    = (state_q == ADDR);
    assign slot_end   = (slot_q == SW'(WIN - 1));
    assign addr_first = in_addr && (gest_q == '0) && (slot_q == '0);
    assign addr_last  = in_addr && (gest_q == GW'(NUM_GEST - 1)) && slot_end;

    mv_history_ram u_hist (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_clear   (i_clear),
        .i_we      (we),
        .i_wdata   (wdata),
        .i_rd_slot (slot_q),
        .o_rd_data (hist_rd)
    );

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        arm_d     = arm_q;
        pend_v_d  = pend_v_q;
        pend_d    = pend_q;
        gest_d    = gest_q;
        slot_d    = slot_q;
        drain_d   = drain_q;
        overrun_d = 1'b0;
        we        = 1'b0;
        wdata     = mv_in;

        if (i_clear) begin
            state_d  = FILL;
            count_d  = '0;
            arm_d    = 1'b0;
            pend_v_d = 1'b0;
            gest_d   = '0;
            slot_d   = '0;
            drain_d  = 1'b0;
        end else begin
            case (state_q)
                FILL: begin
                    if (i_mv_valid) begin
                        we      = 1'b1;
                        count_d = count_q + 1'b1;
                        if (count_q == CW'(WIN - 1)) begin
                            state_d = IDLE;
                            arm_d   = 1'b1;
                        end
                    end
                end
                IDLE: begin
                    if (i_mv_valid) begin
                        we    = 1'b1;
                        arm_d = 1'b1;
                    end
                    if (arm_q && i_dst_ready) begin
                        state_d = ADDR;
                        gest_d  = '0;
                        slot_d  = '0;
                        // A vector written on this edge is already in the launched window.
                        arm_d   = 1'b0;
                    end
                end
                ADDR: begin
                    if (i_mv_valid) begin
                        pend_d    = mv_in;
                        pend_v_d  = 1'b1;
                        overrun_d = pend_v_q;
                    end
                    slot_d = slot_q + 1'b1;
                    if (slot_end) begin
                        gest_d = gest_q + 1'b1;
                        if (gest_q == GW'(NUM_GEST - 1)) begin
                            gest_d  = '0;
                            state_d = DRAIN;
                            drain_d = 1'b0;
                        end
                    end
                end
                default: begin // DRAIN
                    if (!drain_q) begin
                        drain_d = 1'b1;
                        if (i_mv_valid) begin
                            pend_d    = mv_in;
                            pend_v_d  = 1'b1;
                            overrun_d = pend_v_q;
                        end
                    end else begin
                        // Commit on IDLE entry; a vector arriving now supersedes the pending one.
                        state_d  = IDLE;
                        drain_d  = 1'b0;
                        pend_v_d = 1'b0;
                        if (i_mv_valid || pend_v_q) begin
                            we        = 1'b1;
                            wdata     = i_mv_valid ? mv_in : pend_q;
                            arm_d     = 1'b1;
                            overrun_d = i_mv_valid && pend_v_q;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= FILL;
            count_q    <= '0;
            arm_q      <= 1'b0;
            pend_v_q   <= 1'b0;
            pend_q     <= '0;
            gest_q     <= '0;
            slot_q     <= '0;
            drain_q    <= 1'b0;
            overrun_q  <= 1'b0;
            v1_q       <= 1'b0;
            first1_q   <= 1'b0;
            last1_q    <= 1'b0;
            gest1_q    <= '0;
            slot1_q    <= '0;
            valid_q    <= 1'b0;
            first_q    <= 1'b0;
            last_q     <= 1'b0;
            out_gest_q <= '0;
            out_slot_q <= '0;
            vec_q      <= '0;
            lib_q      <= '0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            arm_q     <= arm_d;
            pend_v_q  <= pend_v_d;
            pend_q    <= pend_d;
            gest_q    <= gest_d;
            slot_q    <= slot_d;
            drain_q   <= drain_d;
            overrun_q <= overrun_d;
            gest1_q   <= gest_q;
            slot1_q   <= slot_q;
            if (i_clear) begin
                v1_q     <= 1'b0;
                first1_q <= 1'b0;
                last1_q  <= 1'b0;
                valid_q  <= 1'b0;
                first_q  <= 1'b0;
                last_q   <= 1'b0;
            end else begin
                v1_q     <= in_addr;
                first1_q <= addr_first;
                last1_q  <= addr_last;
                valid_q  <= v1_q;
                first_q  <= first1_q;
                last_q   <= last1_q;
                if (v1_q) begin
                    out_gest_q <= gest1_q;
                    out_slot_q <= slot1_q;
                    vec_q      <= mv_t'(hist_rd);
                    lib_q      <= {i_lib_x, i_lib_y};
                end
            end
        end
    end

    assign o_lib_en   = in_addr;
    assign o_lib_addr = {gest_q, slot_q};
    assign o_valid    = valid_q;
    assign o_first    = first_q;
    assign o_last     = last_q;
    assign o_gest     = out_gest_q;
    assign o_slot     = out_slot_q;
    assign o_vec_x    = vec_q.x;
    assign o_vec_y    = vec_q.y;
    assign o_lib_x    = lib_q.x;
    assign o_lib_y    = lib_q.y;
    assign o_full     = (count_q == CW'(WIN));
    assign o_overrun  = overrun_q;

endmodule

// File: tb/tb_motion_window_streamer.sv
// tb/tb_motion_window_streamer.sv - scoreboard bench for motion_window_streamer
module tb_motion_window_streamer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       mv_valid = 1'b0;
    logic [5:0] mv_x = '0, mv_y = '0;
    logic       clear = 1'b0;
    logic       dst_ready = 1'b0;
    logic       lib_en;
    logic [8:0] lib_addr;
    logic [5:0] rom_x = '0, rom_y = '0;
    logic       o_valid, o_first, o_last, o_full, o_overrun;
    logic [4:0] o_gest;
    logic [3:0] o_slot;
    logic [5:0] o_vec_x, o_vec_y, o_lib_x, o_lib_y;

    always #5 clk = ~clk;

    motion_window_streamer dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_mv_valid  (mv_valid),
        .i_mv_x      (mv_x),
        .i_mv_y      (mv_y),
        .i_clear     (clear),
        .i_dst_ready (dst_ready),
        .o_lib_en    (lib_en),
        .o_lib_addr  (lib_addr),
        .i_lib_x     (rom_x),
        .i_lib_y     (rom_y),
        .o_valid     (o_valid),
        .o_first     (o_first),
        .o_last      (o_last),
        .o_gest      (o_gest),
        .o_slot      (o_slot),
        .o_vec_x     (o_vec_x),
        .o_vec_y     (o_vec_y),
        .o_lib_x     (o_lib_x),
        .o_lib_y     (o_lib_y),
        .o_full      (o_full),
        .o_overrun   (o_overrun)
    );

    // Library ROM: x = addr[5:0], y = ~addr[5:0], one cycle latency.
    always @(posedge clk) begin
        if (lib_en) begin
            rom_x <= lib_addr[5:0];
            rom_y <= ~lib_addr[5:0];
        end
    end

    typedef struct {
        logic       first;
        logic       last;
        logic [4:0] g;
        logic [3:0] s;
        logic [5:0] vx, vy, lx, ly;
    } beat_t;

    beat_t      sb[$];
    logic [5:0] hx[16], hy[16];
    int         mwp = 0;
    logic [5:0] cap_vx[416], cap_vy[416];

    int n_checks = 0, n_fail = 0;
    int cyc = 0, en_cnt = 0, en_cyc = 0, first_cyc = 0, last_cyc = 0;
    int last_cnt = 0, ovr_cnt = 0, beats_seen = 0;
    logic en_prev = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [11:0] v12(input int x, input int y);
        return {6'(x), 6'(y)};
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: pops and compares every presented beat.
    initial begin : mon
        beat_t e;
        int    idx;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                en_prev = 1'b0;
            end else begin
                if (lib_en) begin
                    en_cnt++;
                    if (!en_prev) en_cyc = cyc;
                end
                en_prev = lib_en;
                if (o_overrun) ovr_cnt++;
                if (o_valid) begin
                    if (o_first) first_cyc = cyc;
                    if (o_last) begin
                        last_cyc = cyc;
                        last_cnt++;
                    end
                    if (sb.size() == 0) begin
                        chk("unexpected_beat", 64'(o_gest * 16 + o_slot), 64'hFFFF);
                    end else begin
                        e = sb.pop_front();
                        chk("beat", 64'({o_first, o_last, o_gest, o_slot, o_vec_x, o_vec_y, o_lib_x, o_lib_y}),
                            64'({e.first, e.last, e.g, e.s, e.vx, e.vy, e.lx, e.ly}));
                        idx = o_gest * 16 + o_slot;
                        if (idx < 416) begin
                            cap_vx[idx] = o_vec_x;
                            cap_vy[idx] = o_vec_y;
                        end
                        beats_seen++;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic commit(input int x, input int y);
        hx[mwp] = 6'(x);
        hy[mwp] = 6'(y);
        mwp = (mwp + 1) % 16;
    endtask

    task automatic send(input int x, input int y);
        mv_x = 6'(x);
        mv_y = 6'(y);
        mv_valid = 1'b1;
        tick();
        mv_valid = 1'b0;
    endtask

    task automatic push_stream();
        beat_t      b;
        int         sl;
        logic [8:0] a;
        for (int n = 0; n < 416; n++) begin
            sl      = n % 16;
            a       = 9'(n);
            b.first = (n == 0);
            b.last  = (n == 415);
            b.g     = 5'(n / 16);
            b.s     = 4'(sl);
            b.vx    = hx[(mwp + sl) % 16];
            b.vy    = hy[(mwp + sl) % 16];
            b.lx    = a[5:0];
            b.ly    = ~a[5:0];
            sb.push_back(b);
        end
    endtask

    task automatic wait_empty(input string nm, input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        chk(nm, 64'(sb.size()), 64'd0);
        repeat (4) tick();
    endtask

    task automatic wait_beats(input int target, input int budget);
        int n;
        n = 0;
        while (beats_seen < target && n < budget) begin
            tick();
            n++;
        end
        chk("beat_wait", 64'(beats_seen >= target), 64'd1);
    endtask

    // Fill 16 vectors (x=k, y=-k) from empty and check the resulting stream.
    task automatic fill_and_stream(input string tag);
        int en0, l0;
        en0 = en_cnt;
        l0  = last_cnt;
        for (int k = 0; k < 15; k++) begin
            commit(k, -k);
            send(k, -k);
            tick();
        end
        chk({tag, "_no_lib_en_fill"}, 64'(en_cnt - en0), 64'd0);
        chk({tag, "_not_full_15"}, 64'(o_full), 64'd0);
        commit(15, -15);
        push_stream();
        send(15, -15);
        wait_empty({tag, "_stream_done"}, 1000);
        chk({tag, "_latency"}, 64'(first_cyc - en_cyc), 64'd2);
        chk({tag, "_contiguous"}, 64'(last_cyc - first_cyc), 64'd415);
        chk({tag, "_lib_en_cycles"}, 64'(en_cnt - en0), 64'd416);
        chk({tag, "_one_last"}, 64'(last_cnt - l0), 64'd1);
        chk({tag, "_beat0_vec"}, 64'({cap_vx[0], cap_vy[0]}), 64'(v12(0, 0)));
        chk({tag, "_beat15_vec"}, 64'({cap_vx[15], cap_vy[15]}), 64'(v12(15, -15)));
        chk({tag, "_full"}, 64'(o_full), 64'd1);
    endtask

    initial begin
        int en0, b0, l0, o0;

        // 1: reset and first stream
        rst_n = 1'b0;
        repeat (3) tick();
        chk("reset_outputs", 64'({lib_en, lib_addr, o_valid, o_first, o_last, o_gest, o_slot, o_full, o_overrun}), 64'd0);
        chk("reset_vectors", 64'({o_vec_x, o_vec_y, o_lib_x, o_lib_y}), 64'd0);
        rst_n = 1'b1;
        dst_ready = 1'b1;
        tick();
        fill_and_stream("t1");

        // 3: A then B during a stream; B survives and wraps into slot 15
        o0 = ovr_cnt;
        commit(16, -16);
        push_stream();
        send(16, -16);
        repeat (50) tick();
        send(20, -20);
        repeat (3) tick();
        send(-7, 9);
        commit(-7, 9);
        push_stream();
        wait_empty("t3_streams_done", 2000);
        chk("t3_overrun_once", 64'(ovr_cnt - o0), 64'd1);
        chk("t3_slot0_oldest", 64'({cap_vx[0], cap_vy[0]}), 64'(v12(2, -2)));
        chk("t3_slot14_wrap", 64'({cap_vx[14], cap_vy[14]}), 64'(v12(16, -16)));
        chk("t3_slot15_B", 64'({cap_vx[15], cap_vy[15]}), 64'(v12(-7, 9)));

        // 4: held-off launch, exactly one stream once ready rises
        dst_ready = 1'b0;
        commit(5, 6);
        send(5, 6);
        en0 = en_cnt;
        b0  = beats_seen;
        repeat (100) tick();
        chk("t4_no_lib_en_blocked", 64'(en_cnt - en0), 64'd0);
        chk("t4_no_beats_blocked", 64'(beats_seen - b0), 64'd0);
        push_stream();
        dst_ready = 1'b1;
        wait_empty("t4_stream_done", 1000);
        repeat (500) tick();
        chk("t4_one_stream_en", 64'(en_cnt - en0), 64'd416);
        chk("t4_one_stream_beats", 64'(beats_seen - b0), 64'd416);

        // 5: clear mid-stream
        commit(7, -8);
        push_stream();
        l0 = last_cnt;
        b0 = beats_seen;
        send(7, -8);
        wait_beats(b0 + 200, 1000);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        sb.delete();
        @(negedge clk);
        chk("t5_valid_after_clear", 64'(o_valid), 64'd0);
        chk("t5_lib_en_after_clear", 64'(lib_en), 64'd0);
        repeat (20) tick();
        chk("t5_no_last", 64'(last_cnt - l0), 64'd0);
        chk("t5_not_full", 64'(o_full), 64'd0);
        mwp = 0;
        for (int k = 0; k < 16; k++) begin
            commit(k + 10, k - 20);
            if (k == 15) push_stream();
            send(k + 10, k - 20);
            tick();
        end
        wait_empty("t5_refill_stream", 1000);
        chk("t5_beat0_vec", 64'({cap_vx[0], cap_vy[0]}), 64'(v12(10, -20)));
        chk("t5_beat15_vec", 64'({cap_vx[15], cap_vy[15]}), 64'(v12(25, -5)));

        // 6: async reset mid-ADDR
        commit(3, 3);
        push_stream();
        b0 = beats_seen;
        send(3, 3);
        wait_beats(b0 + 50, 1000);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async_outputs", 64'({lib_en, lib_addr, o_valid, o_first, o_last, o_gest, o_slot, o_full, o_overrun}), 64'd0);
        chk("t6_async_vectors", 64'({o_vec_x, o_vec_y, o_lib_x, o_lib_y}), 64'd0);
        sb.delete();
        mwp = 0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        fill_and_stream("t6");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
